// File: rtl/tick_sched.sv
// Shared prescaler issuing single-cycle fast/slow/selected clock-enable ticks,
// with a start/stop/single-step control FSM. All outputs are registered.
module tick_sched #(
  parameter int FAST_DIV = 2_500_000,
  parameter int RATIO    = 4,
  parameter int P_W      = $clog2(FAST_DIV),
  parameter int R_W      = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic stop,
  input  logic step,
  input  logic fast_sel,
  output logic fast_tick,
  output logic slow_tick,
  output logic tick,
  output logic busy
);

  // Requests are single-cycle pulses with no ready: each is sampled on every
  // edge, priority stop > start > step, and a request that does not apply in
  // the current state is dropped rather than held.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;

  state_t         state;
  logic [P_W-1:0] p;
  logic [R_W-1:0] r;
  logic           step_sel;

  logic fast_term;
  logic slow_term;
  logic eff_sel;
  logic sel_term;

  assign fast_term = (p == P_W'(FAST_DIV - 1));
  assign slow_term = fast_term && (r == R_W'(RATIO - 1));
  // A start arriving during STEP hands over to RUN on this very edge,
  // so the live fast_sel already governs the tick emitted here.
  assign eff_sel   = (state == STEP && !start) ? step_sel : fast_sel;
  assign sel_term  = eff_sel ? fast_term : slow_term;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      p         <= '0;
      r         <= '0;
      step_sel  <= 1'b0;
      fast_tick <= 1'b0;
      slow_tick <= 1'b0;
      tick      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      fast_tick <= 1'b0;
      slow_tick <= 1'b0;
      tick      <= 1'b0;
      if (stop) begin
        state <= IDLE;
        p     <= '0;
        r     <= '0;
        busy  <= 1'b0;
      end else if (state == IDLE) begin
        p <= '0;
        r <= '0;
        if (start) begin
          state <= RUN;
          busy  <= 1'b1;
        end else if (step) begin
          state    <= STEP;
          step_sel <= fast_sel;
          busy     <= 1'b1;
        end else begin
          busy <= 1'b0;
        end
      end else begin
        fast_tick <= fast_term;
        slow_tick <= slow_term;
        tick      <= sel_term;
        p         <= fast_term ? '0 : p + P_W'(1);
        if (fast_term) begin
          r <= (r == R_W'(RATIO - 1)) ? '0 : r + R_W'(1);
        end
        if (state == STEP && !start && sel_term) begin
          // Single step done: tick and busy-fall share this edge.
          state <= IDLE;
          p     <= '0;
          r     <= '0;
          busy  <= 1'b0;
        end else begin
          if (start) state <= RUN;
          busy <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tick_sched.sv
// Bench for tick_sched: directed scenarios plus random request traffic, checked
// every cycle against a model that counts edges elapsed since the time base began.
module tb_tick_sched;
  localparam int FAST_DIV = 5;
  localparam int RATIO    = 3;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STEP = 2;

  logic clk = 1'b0;
  logic rst, start, stop, step, fast_sel;
  logic fast_tick, slow_tick, tick, busy;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  // Reference model: mode plus edges elapsed since the start/step edge.
  int   m_mode = M_IDLE;
  int   m_e    = 0;
  logic m_lsel = 1'b0;

  always #5 clk = ~clk;

  tick_sched #(.FAST_DIV(FAST_DIV), .RATIO(RATIO)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step),
    .fast_sel(fast_sel), .fast_tick(fast_tick), .slow_tick(slow_tick),
    .tick(tick), .busy(busy)
  );

  task automatic model_edge();
    logic ft, st, tk, sel;
    ft = 1'b0; st = 1'b0; tk = 1'b0;
    if (rst || stop) begin
      m_mode = M_IDLE; m_e = 0;
    end else if (m_mode == M_IDLE) begin
      if (start) begin
        m_mode = M_RUN; m_e = 0;
      end else if (step) begin
        m_mode = M_STEP; m_e = 0; m_lsel = fast_sel;
      end
    end else begin
      if (start) m_mode = M_RUN;
      m_e = m_e + 1;
      ft  = (m_e % FAST_DIV) == 0;
      st  = (m_e % (FAST_DIV * RATIO)) == 0;
      sel = (m_mode == M_RUN) ? fast_sel : m_lsel;
      tk  = sel ? ft : st;
      if (m_mode == M_STEP && tk) begin
        m_mode = M_IDLE; m_e = 0;
      end
    end
    exp_q.push_back({ft, st, tk, (m_mode != M_IDLE)});
  endtask

  task automatic check_outputs(input string tag);
    logic [3:0] exp, obs;
    obs = {fast_tick, slow_tick, tick, busy};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, observed %b", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s @%0t: {fast,slow,tick,busy} observed %b expected %b", tag, $time, obs, exp);
      end
    end
  endtask

  // One clock: apply requests, let the edge happen, then compare just after it.
  task automatic cyc(input string tag, input logic s, input logic p,
                     input logic t, input logic f, input logic r);
    start = s; stop = p; step = t; fast_sel = f; rst = r;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
    start = 1'b0; stop = 1'b0; step = 1'b0; rst = 1'b0;
  endtask

  task automatic idle_cycles(input string tag, input int n, input logic f);
    for (int i = 0; i < n; i++) cyc(tag, 1'b0, 1'b0, 1'b0, f, 1'b0);
  endtask

  initial begin
    int n_ticks;
    rst = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0; fast_sel = 1'b0;

    // Reset state
    for (int i = 0; i < 3; i++) cyc("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Free run, fast select
    cyc("run_start", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_cycles("run_fast", 35, 1'b1);
    cyc("run_stop", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Single slow step: exactly one tick over the following window
    idle_cycles("idle", 3, 1'b0);
    cyc("step_slow_req", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_ticks = 0;
    for (int i = 0; i < 66; i++) begin
      cyc("step_slow", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (tick) n_ticks++;
    end
    checks++;
    assert (n_ticks === 1) else begin
      errors++;
      $error("FAIL step_tick_count: observed %0d expected 1", n_ticks);
    end

    // Stop on a fast terminal, then restart
    cyc("stop_term_start", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_cycles("stop_term_run", 9, 1'b1);
    cyc("stop_term", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle_cycles("stop_term_idle", 3, 1'b1);
    cyc("restart", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_cycles("restart_run", 8, 1'b1);
    cyc("restart_stop", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Latched select survives a fast_sel toggle mid-step
    cyc("step_latch_req", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_cycles("step_latch", 20, 1'b1);

    // Start during STEP at edge 7 hands over to RUN
    cyc("step_start_req", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_cycles("step_pre", 6, 1'b0);
    cyc("step_to_run", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_cycles("step_to_run_after", 10, 1'b1);
    cyc("s2r_stop", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Simultaneous requests
    cyc("start_stop", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle_cycles("start_stop_idle", 2, 1'b1);
    cyc("step_start", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_cycles("step_start_run", 6, 1'b1);
    cyc("ss_stop", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Reset mid-run at edge 12
    cyc("rst_run_start", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_cycles("rst_run", 11, 1'b1);
    cyc("rst_mid", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    idle_cycles("rst_after", 6, 1'b1);

    // Random request traffic
    for (int i = 0; i < 4000; i++) begin
      logic f;
      f = fast_sel;
      if ($urandom_range(0, 99) < 5) f = ~f;
      cyc("random",
          $urandom_range(0, 99) < 2,
          $urandom_range(0, 199) < 2,
          $urandom_range(0, 99) < 3,
          f,
          $urandom_range(0, 999) < 4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
